// File: rtl/obj_scroll_pkg.sv
// Shared definitions for the multi-channel object scroller: state codes,
// lane decode, channel FSM states and default geometry constants.
package obj_scroll_pkg;

    localparam logic [2:0] ST_UP_A = 3'd1;
    localparam logic [2:0] ST_DN_A = 3'd2;
    localparam logic [2:0] ST_DN_B = 3'd5;
    localparam logic [2:0] ST_UP_B = 3'd6;

    localparam int DEF_LANE_UP_V = 60;
    localparam int DEF_LANE_DN_V = 300;
    localparam int DEF_HIDE_V    = 500;
    localparam int DEF_OBJ_W     = 30;
    localparam int DEF_OBJ_H     = 30;

    typedef enum logic {MOVE, HOLD} chan_state_e;

    typedef enum logic [1:0] {LANE_UP, LANE_DN, LANE_HIDE} lane_e;

    function automatic lane_e lane_decode(input logic [2:0] code);
        lane_e lane;
        case (code)
            ST_UP_A, ST_UP_B: lane = LANE_UP;
            ST_DN_A, ST_DN_B: lane = LANE_DN;
            default:          lane = LANE_HIDE;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/obj_scroll_chan.sv
// One scroller channel: horizontal position, MOVE/HOLD FSM with respawn hold
// counter, registered lane position, visibility and wrap pulse.
module obj_scroll_chan
    import obj_scroll_pkg::*;
#(
    parameter int HW         = 10,
    parameter int SCREEN_W   = 850,
    parameter int H_INIT     = 0,
    parameter int SPEED_W    = 3,
    parameter int HOLD_TICKS = 2,
    parameter int LANE_UP_V  = DEF_LANE_UP_V,
    parameter int LANE_DN_V  = DEF_LANE_DN_V,
    parameter int HIDE_V     = DEF_HIDE_V
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic [SPEED_W-1:0] speed,
    input  logic [2:0]         code,
    output logic [HW-1:0]      h,
    output logic [HW-1:0]      v,
    output logic               visible,
    output logic               wrap_pulse
);

    localparam int CNT_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0]    H_MAX     = HW'(SCREEN_W - 1);
    localparam logic [HW-1:0]    H_RST     = HW'(H_INIT);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_TICKS);

    chan_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [HW-1:0]    h_nxt, v_nxt, spd_ext;
    logic             vis_nxt, wrap_nxt;
    lane_e            lane;

    assign spd_ext = HW'(speed);
    assign lane    = lane_decode(code);

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        if (step) begin
            case (state)
                MOVE: begin
                    if (h >= spd_ext) begin
                        h_nxt = h - spd_ext;
                    end else begin
                        h_nxt    = H_MAX;
                        wrap_nxt = 1'b1;
                        if (HOLD_TICKS != 0) begin
                            state_nxt = HOLD;
                            cnt_nxt   = HOLD_INIT;
                        end
                    end
                end
                HOLD: begin
                    h_nxt   = H_MAX;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = MOVE;
                end
                default: state_nxt = MOVE;
            endcase
        end

        // Lane follows the state being entered so v/visible line up with h.
        v_nxt   = HW'(HIDE_V);
        vis_nxt = 1'b0;
        if (state_nxt == MOVE) begin
            case (lane)
                LANE_UP: begin v_nxt = HW'(LANE_UP_V); vis_nxt = 1'b1; end
                LANE_DN: begin v_nxt = HW'(LANE_DN_V); vis_nxt = 1'b1; end
                default: begin v_nxt = HW'(HIDE_V);    vis_nxt = 1'b0; end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MOVE;
            cnt        <= '0;
            h          <= H_RST;
            v          <= HW'(HIDE_V);
            visible    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            h          <= h_nxt;
            v          <= v_nxt;
            visible    <= vis_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

endmodule

// File: rtl/obj_scroll_multi.sv
// N_OBJ-channel object scroller with reset stagger and constant size outputs.
// Define OBJ_SCROLL_WRAP_COUNT_EN to build the saturating 16-bit wrap counter.
module obj_scroll_multi
    import obj_scroll_pkg::*;
#(
    parameter int N_OBJ      = 4,
    parameter int HW         = 10,
    parameter int SCREEN_W   = 850,
    parameter int SPACING    = 212,
    parameter int SPEED_W    = 3,
    parameter int HOLD_TICKS = 2,
    parameter int LANE_UP_V  = DEF_LANE_UP_V,
    parameter int LANE_DN_V  = DEF_LANE_DN_V,
    parameter int HIDE_V     = DEF_HIDE_V,
    parameter int OBJ_W      = DEF_OBJ_W,
    parameter int OBJ_H      = DEF_OBJ_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  run,
    input  logic [SPEED_W-1:0]    speed,
    input  logic [3*N_OBJ-1:0]    obj_state,
    output logic [HW*N_OBJ-1:0]   obj_h,
    output logic [HW*N_OBJ-1:0]   obj_v,
    output logic [N_OBJ-1:0]      obj_visible,
    output logic [N_OBJ-1:0]      wrap_pulse,
    output logic [HW-1:0]         obj_w,
    output logic [HW-1:0]         obj_h_size,
    output logic [15:0]           wrap_cnt
);

    logic step;
    assign step = tick & run;

    if (SCREEN_W - 1 >= (1 << HW)) begin : g_width_check
        $error("obj_scroll_multi: SCREEN_W-1 does not fit in HW bits");
    end

    for (genvar i = 0; i < N_OBJ; i++) begin : g_chan
        obj_scroll_chan #(
            .HW         (HW),
            .SCREEN_W   (SCREEN_W),
            .H_INIT     ((i * SPACING) % SCREEN_W),
            .SPEED_W    (SPEED_W),
            .HOLD_TICKS (HOLD_TICKS),
            .LANE_UP_V  (LANE_UP_V),
            .LANE_DN_V  (LANE_DN_V),
            .HIDE_V     (HIDE_V)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .step       (step),
            .speed      (speed),
            .code       (obj_state[3*i +: 3]),
            .h          (obj_h[HW*i +: HW]),
            .v          (obj_v[HW*i +: HW]),
            .visible    (obj_visible[i]),
            .wrap_pulse (wrap_pulse[i])
        );
    end

    assign obj_w      = HW'(OBJ_W);
    assign obj_h_size = HW'(OBJ_H);

`ifdef OBJ_SCROLL_WRAP_COUNT_EN
    // Simultaneous wraps all count; the 17th bit flags saturation.
    logic [16:0] wrap_sum;

    always_comb begin
        wrap_sum = {1'b0, wrap_cnt};
        for (int i = 0; i < N_OBJ; i++) begin
            wrap_sum = wrap_sum + 17'(wrap_pulse[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrap_cnt <= '0;
        else        wrap_cnt <= wrap_sum[16] ? 16'hFFFF : wrap_sum[15:0];
    end
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_obj_scroll_multi.sv
// Directed bench for obj_scroll_multi at default parameters: a vector table
// for the first wrap/hold sequence, then hand-written multi-cycle corners.
module tb_obj_scroll_multi;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        run;
    logic [2:0]  speed;
    logic [11:0] obj_state;
    logic [39:0] obj_h;
    logic [39:0] obj_v;
    logic [3:0]  obj_visible;
    logic [3:0]  wrap_pulse;
    logic [9:0]  obj_w;
    logic [9:0]  obj_h_size;
    logic [15:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    obj_scroll_multi dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .run         (run),
        .speed       (speed),
        .obj_state   (obj_state),
        .obj_h       (obj_h),
        .obj_v       (obj_v),
        .obj_visible (obj_visible),
        .wrap_pulse  (wrap_pulse),
        .obj_w       (obj_w),
        .obj_h_size  (obj_h_size),
        .wrap_cnt    (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        run;
        logic [2:0]  speed;
        logic [39:0] eh;
        logic [39:0] ev;
        logic [3:0]  evis;
        logic [3:0]  ewrap;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [39:0] p4(input int c0, input int c1, input int c2, input int c3);
        return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [39:0] eh, input logic [39:0] ev,
                             input logic [3:0] evis, input logic [3:0] ewrap);
        check({name, " h"},    64'(obj_h),       64'(eh));
        check({name, " v"},    64'(obj_v),       64'(ev));
        check({name, " vis"},  64'(obj_visible), 64'(evis));
        check({name, " wrap"}, 64'(wrap_pulse),  64'(ewrap));
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic cyc(input logic t, input logic r, input logic [2:0] s);
        tick  = t;
        run   = r;
        speed = s;
        @(negedge clk);
    endtask

    localparam logic [39:0] V_ALL_UP = {10'd60, 10'd60, 10'd60, 10'd60};
    localparam logic [39:0] V_HOLD0  = {10'd60, 10'd60, 10'd60, 10'd500};

    initial begin
        vecs[0] = '{1'b0, 1'b1, 3'd1, p4(0, 212, 424, 636),   V_ALL_UP, 4'hF, 4'h0};
        vecs[1] = '{1'b1, 1'b1, 3'd1, p4(849, 211, 423, 635), V_HOLD0,  4'hE, 4'h1};
        vecs[2] = '{1'b0, 1'b1, 3'd1, p4(849, 211, 423, 635), V_HOLD0,  4'hE, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 3'd1, p4(849, 210, 422, 634), V_HOLD0,  4'hE, 4'h0};
        vecs[4] = '{1'b1, 1'b1, 3'd1, p4(849, 209, 421, 633), V_ALL_UP, 4'hF, 4'h0};
        vecs[5] = '{1'b1, 1'b1, 3'd1, p4(848, 208, 420, 632), V_ALL_UP, 4'hF, 4'h0};
        vecs[6] = '{1'b1, 1'b0, 3'd5, p4(848, 208, 420, 632), V_ALL_UP, 4'hF, 4'h0};
        vecs[7] = '{1'b1, 1'b1, 3'd0, p4(848, 208, 420, 632), V_ALL_UP, 4'hF, 4'h0};

        rst_n     = 1'b0;
        tick      = 1'b0;
        run       = 1'b1;
        speed     = 3'd1;
        obj_state = 12'h249;
        #12;
        check_all("reset", p4(0, 212, 424, 636), {4{10'd500}}, 4'h0, 4'h0);
        check("obj_w", 64'(obj_w), 64'd30);
        check("obj_h_size", 64'(obj_h_size), 64'd30);
        check("wrap_cnt reset", 64'(wrap_cnt), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].tick, vecs[i].run, vecs[i].speed);
            check_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ev, vecs[i].evis, vecs[i].ewrap);
        end

        repeat (41) cyc(1'b1, 1'b1, 3'd5);
        check_all("speed5 x41", p4(643, 3, 215, 427), V_ALL_UP, 4'hF, 4'h0);

        // Lane change without a step: v follows next cycle, h untouched.
        obj_state = 12'h251;
        cyc(1'b0, 1'b1, 3'd5);
        check_all("lane change", p4(643, 3, 215, 427),
                  {10'd60, 10'd60, 10'd300, 10'd60}, 4'hF, 4'h0);

        cyc(1'b1, 1'b1, 3'd5);
        check_all("ch1 underflow", p4(638, 849, 210, 422),
                  {10'd60, 10'd60, 10'd500, 10'd60}, 4'hD, 4'h2);
        cyc(1'b0, 1'b1, 3'd5);
        check("wrap one cycle", 64'(wrap_pulse), 64'd0);

        repeat (41) cyc(1'b1, 1'b1, 3'd5);
        check("ch2 at 5", 64'(obj_h[29:20]), 64'd5);
        cyc(1'b1, 1'b1, 3'd5);
        check_all("ch2 exact zero", p4(428, 649, 0, 212),
                  {10'd60, 10'd60, 10'd300, 10'd60}, 4'hF, 4'h0);

        cyc(1'b1, 1'b1, 3'd5);
        check_all("ch2 wrap", p4(423, 644, 849, 207),
                  {10'd60, 10'd500, 10'd300, 10'd60}, 4'hB, 4'h4);

        repeat (3) cyc(1'b1, 1'b0, 3'd5);
        check_all("run0 hold kept", p4(423, 644, 849, 207),
                  {10'd60, 10'd500, 10'd300, 10'd60}, 4'hB, 4'h0);
        cyc(1'b1, 1'b1, 3'd0);
        check_all("speed0 hold cnt1", p4(423, 644, 849, 207),
                  {10'd60, 10'd500, 10'd300, 10'd60}, 4'hB, 4'h0);
        cyc(1'b1, 1'b1, 3'd0);
        check_all("speed0 hold done", p4(423, 644, 849, 207),
                  {10'd60, 10'd60, 10'd300, 10'd60}, 4'hF, 4'h0);
        cyc(1'b1, 1'b1, 3'd1);
        check_all("first move", p4(422, 643, 848, 206),
                  {10'd60, 10'd60, 10'd300, 10'd60}, 4'hF, 4'h0);

`ifdef OBJ_SCROLL_WRAP_COUNT_EN
        check("wrap_cnt total", 64'(wrap_cnt), 64'd3);
`else
        check("wrap_cnt tied", 64'(wrap_cnt), 64'd0);
`endif

        // Asynchronous reset between clock edges.
        cyc(1'b1, 1'b1, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", p4(0, 212, 424, 636), {4{10'd500}}, 4'h0, 4'h0);
        check("async reset wrap_cnt", 64'(wrap_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
